// File: rtl/counter_pulse_sched_pkg.sv
// ----------------------------------------------------------------------------
// counter_pulse_sched_pkg
// Shared types and defaults for the counter pulse scheduler.
//   cmd_e    : requester command encoding (NOP, INCR, CLEAR, INCR_N)
//   state_e  : scheduler FSM states (IDLE, GRANT, ISSUE, GAP)
//   CNT_W_DEF: default shadow counter width
//   LEN_W_DEF: default INCR_N burst-length field width
// ----------------------------------------------------------------------------
package counter_pulse_sched_pkg;

   localparam int CNT_W_DEF = 1;
   localparam int LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      NOP    = 2'b00,
      INCR   = 2'b01,
      CLEAR  = 2'b10,
      INCR_N = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      ISSUE = 2'b10,
      GAP   = 2'b11
   } state_e;

   // A command produces at least one pulse unless it is NOP or an empty INCR_N.
   function automatic logic cmd_has_pulse(cmd_e cmd, logic len_nz);
      logic has_pulse;
      unique case (cmd)
         INCR, CLEAR: has_pulse = 1'b1;
         INCR_N:      has_pulse = len_nz;
         default:     has_pulse = 1'b0;
      endcase
      return has_pulse;
   endfunction

endpackage

// File: rtl/counter_pulse_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the current
// requests and the priority pointer; the pointer moves only when the caller
// pulses advance, so the grant may be inspected freely outside GRANT.
//   clk     in   clock
//   rst     in   synchronous active-high reset (pointer favours req[0])
//   req     in   [1:0] request vector
//   advance in   a grant was consumed this cycle; rotate priority
//   gnt     out  [1:0] one-hot grant (or zero when no request)
// ----------------------------------------------------------------------------
module rr_arb2
   import counter_pulse_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // prio1_q set means requester 1 wins a tie (requester 0 was served last).
   logic prio1_q;
   logic prio1_d;

   always_comb begin
      gnt     = 2'b00;
      prio1_d = prio1_q;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio1_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      if (advance) begin
         prio1_d = gnt[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio1_q <= 1'b0;
      end else begin
         prio1_q <= prio1_d;
      end
   end

endmodule

// File: rtl/counter_pulse_sched.sv
// ----------------------------------------------------------------------------
// counter_pulse_sched
// Arbitrates two requesters onto a single external counter. Each granted
// command is turned into enable / counter-reset pulses spaced two cycles
// apart, while a shadow copy of the expected counter value is maintained.
// Optional build macro CNT_CHECK_EN adds a sticky check of the counter's
// bit 0 against the shadow during every GAP cycle.
//
// Ports
//   GCLK_Pad            in   clock
//   rst_Pad             in   synchronous active-high reset
//   req0_Pad, req1_Pad  in   requests, held until granted
//   cmd0_Pad, cmd1_Pad  in   [1:0] command (NOP/INCR/CLEAR/INCR_N)
//   len0_Pad, len1_Pad  in   [LEN_W-1:0] INCR_N pulse count
//   gnt0_Pad, gnt1_Pad  out  one-cycle grant
//   en_Pad              out  one-cycle counter enable pulse
//   crst_Pad            out  one-cycle counter reset pulse
//   count_Pad           in   counter bit 0 (used only with CNT_CHECK_EN)
//   busy_Pad            out  FSM not in IDLE
//   shadow_Pad          out  [CNT_W-1:0] expected counter value
//   mismatch_Pad        out  sticky counter check failure
//
// FSM states
//   state | meaning
//   IDLE  | waiting for any request
//   GRANT | winner granted, its cmd/len captured
//   ISSUE | one en or crst pulse, remaining count decremented
//   GAP   | quiet cycle between pulses; counter check point
// ----------------------------------------------------------------------------
module counter_pulse_sched
   import counter_pulse_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             GCLK_Pad,
   input  logic             rst_Pad,
   input  logic             req0_Pad,
   input  logic             req1_Pad,
   input  logic [1:0]       cmd0_Pad,
   input  logic [1:0]       cmd1_Pad,
   input  logic [LEN_W-1:0] len0_Pad,
   input  logic [LEN_W-1:0] len1_Pad,
   output logic             gnt0_Pad,
   output logic             gnt1_Pad,
   output logic             en_Pad,
   output logic             crst_Pad,
   input  logic             count_Pad,
   output logic             busy_Pad,
   output logic [CNT_W-1:0] shadow_Pad,
   output logic             mismatch_Pad
);

   state_e           state_q,     state_d;
   cmd_e             cmd_q,       cmd_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] shadow_q,    shadow_d;

   logic [1:0]       arb_gnt;
   logic             arb_adv;
   logic [1:0]       gnt_vec;
   logic             en_pulse;
   logic             crst_pulse;
   cmd_e             win_cmd;
   logic [LEN_W-1:0] win_len;

   rr_arb2 u_arb (
      .clk     (GCLK_Pad),
      .rst     (rst_Pad),
      .req     ({req1_Pad, req0_Pad}),
      .advance (arb_adv),
      .gnt     (arb_gnt)
   );

   // The pointer only rotates when a grant is actually issued; a request
   // that vanished before GRANT leaves the priority untouched.
   assign arb_adv = (state_q == GRANT) && (arb_gnt != 2'b00);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      remaining_d = remaining_q;
      shadow_d    = shadow_q;
      gnt_vec     = 2'b00;
      en_pulse    = 1'b0;
      crst_pulse  = 1'b0;
      win_cmd     = arb_gnt[1] ? cmd_e'(cmd1_Pad) : cmd_e'(cmd0_Pad);
      win_len     = arb_gnt[1] ? len1_Pad : len0_Pad;

      unique case (state_q)
         IDLE: begin
            if (req0_Pad || req1_Pad) begin
               state_d = GRANT;
            end
         end
         GRANT: begin
            state_d = IDLE;
            if (arb_gnt != 2'b00) begin
               gnt_vec = arb_gnt;
               cmd_d   = win_cmd;
               if (cmd_has_pulse(win_cmd, win_len != '0)) begin
                  remaining_d = (win_cmd == INCR_N) ? win_len : LEN_W'(1);
                  state_d     = ISSUE;
               end else begin
                  remaining_d = '0;
               end
            end
         end
         ISSUE: begin
            if (cmd_q == CLEAR) begin
               crst_pulse = 1'b1;
               shadow_d   = '0;
            end else begin
               en_pulse = 1'b1;
               shadow_d = shadow_q + CNT_W'(1);
            end
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = GAP;
         end
         GAP: begin
            state_d = (remaining_q != '0) ? ISSUE : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge GCLK_Pad) begin
      if (rst_Pad) begin
         state_q     <= IDLE;
         cmd_q       <= NOP;
         remaining_q <= '0;
         shadow_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         remaining_q <= remaining_d;
         shadow_q    <= shadow_d;
      end
   end

   // Outputs are forced low while reset is asserted so an aborted burst
   // cannot leak a pulse or grant in the reset cycle itself.
   assign gnt0_Pad   = !rst_Pad && gnt_vec[0];
   assign gnt1_Pad   = !rst_Pad && gnt_vec[1];
   assign en_Pad     = !rst_Pad && en_pulse;
   assign crst_Pad   = !rst_Pad && crst_pulse;
   assign busy_Pad   = !rst_Pad && (state_q != IDLE);
   assign shadow_Pad = rst_Pad ? '0 : shadow_q;

`ifdef CNT_CHECK_EN
   logic mismatch_q, mismatch_d;
   logic cmp_fail;

   // In GAP the counter has absorbed the preceding pulse, as has the shadow.
   always_comb begin
      cmp_fail   = (state_q == GAP) && (count_Pad != shadow_q[0]);
      mismatch_d = mismatch_q | cmp_fail;
   end

   always_ff @(posedge GCLK_Pad) begin
      if (rst_Pad) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end

   // Flag is visible already in the failing GAP cycle.
   assign mismatch_Pad = !rst_Pad && mismatch_d;
`else
   logic unused_count;
   assign unused_count = count_Pad;
   assign mismatch_Pad = 1'b0;
`endif

endmodule
